// File: rtl/port_ext_pkg.sv
// Shared types and helpers for the port_ext_arbiter slice: FSM state encoding,
// length-field width and the round-robin priority mask.
package port_ext_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int RR_MAX = 8;

  function automatic int len_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Bit i set when requester i sits at or after the pointer in priority order.
  function automatic logic [RR_MAX-1:0] rr_mask(input int ptr);
    logic [RR_MAX-1:0] m;
    for (int i = 0; i < RR_MAX; i++) m[i] = (i >= ptr);
    return m;
  endfunction

endpackage

// File: rtl/port_ext_arbiter_extender.sv
// port_extender: widens a value of runtime length to OUT_W by sign or zero
// extension, and flags when the extension filled at least one bit with 1.
module port_extender
  import port_ext_pkg::*;
#(
  parameter int  IN_W  = 2,
  parameter int  OUT_W = 4,
  localparam int LEN_W = len_w(IN_W)
) (
  input  logic [IN_W-1:0]  v,
  input  logic [LEN_W-1:0] len,
  input  logic             s,
  output logic [OUT_W-1:0] ext,
  output logic             fill
);

  logic [OUT_W-1:0] vw;
  logic             sbit;
  int               eff;

  always_comb begin
    vw   = '0;
    ext  = '0;
    fill = 1'b0;
    sbit = 1'b0;
    for (int i = 0; i < IN_W; i++) vw[i] = v[i];
    eff = (int'(len) > IN_W) ? IN_W : int'(len);
    // Bits above the effective length are don't-care; only v[eff-1] can spread.
    for (int i = 0; i < IN_W; i++) begin
      if (i == eff - 1) sbit = s & v[i];
    end
    for (int i = 0; i < OUT_W; i++) ext[i] = (i < eff) ? vw[i] : sbit;
    fill = sbit && (eff < OUT_W);
  end

endmodule

// File: rtl/port_ext_arbiter.sv
// Round-robin arbiter sharing one width-extending valid/ready output port
// between NREQ requesters. Define PORT_EXT_CNT_EN to add the ext_fill_cnt counter.
module port_ext_arbiter
  import port_ext_pkg::*;
#(
  parameter int  NREQ  = 4,
  parameter int  IN_W  = 2,
  parameter int  OUT_W = 4,
  localparam int LEN_W = len_w(IN_W),
  localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*IN_W-1:0]  req_data,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ-1:0]       req_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [SRC_W-1:0]      out_src
`ifdef PORT_EXT_CNT_EN
  ,
  output logic [15:0]           ext_fill_cnt
`endif
);

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   ptr_q;
  logic [SRC_W-1:0]   win;
  logic               any_vld;
  logic               accept;
  logic               take;
  logic [RR_MAX-1:0]  mask_full;
  logic [NREQ-1:0]    masked;
  logic [IN_W-1:0]    win_v;
  logic [LEN_W-1:0]   win_len;
  logic               win_s;
  logic [OUT_W-1:0]   ext_p0;
  logic               fill_p0;
  logic [OUT_W-1:0]   data_p1;
  logic [SRC_W-1:0]   src_p1;

  // Stage p0: winner selection and extension of the winner's fields
  always_comb begin
    mask_full = rr_mask(int'(ptr_q));
    masked    = req_valid & mask_full[NREQ-1:0];
    any_vld   = |req_valid;
    win       = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (req_valid[i]) win = SRC_W'(i);
    for (int i = NREQ - 1; i >= 0; i--) if (masked[i]) win = SRC_W'(i);
  end

  assign accept    = rst_n && ((state_q == IDLE) || out_ready);
  assign take      = accept && any_vld;
  assign req_ready = take ? (NREQ'(1) << win) : '0;

  assign win_v   = req_data[win*IN_W +: IN_W];
  assign win_len = req_len[win*LEN_W +: LEN_W];
  assign win_s   = req_signed[win];

  port_extender #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_ext (
    .v   (win_v),
    .len (win_len),
    .s   (win_s),
    .ext (ext_p0),
    .fill(fill_p0)
  );

  always_comb begin
    state_d = state_q;
    if (take) state_d = HOLD;
    else if ((state_q == HOLD) && out_ready) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Stage p1: registered output transfer and pointer update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p1 <= '0;
      src_p1  <= '0;
      ptr_q   <= '0;
    end else if (take) begin
      data_p1 <= ext_p0;
      src_p1  <= win;
      ptr_q   <= (win == SRC_W'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = data_p1;
  assign out_src   = src_p1;

`ifdef PORT_EXT_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                cnt_q <= '0;
    else if (take && fill_p0)  cnt_q <= cnt_q + 16'd1;
  end

  assign ext_fill_cnt = cnt_q;
`else
  logic fill_unused;
  assign fill_unused = fill_p0;
`endif

endmodule

// File: tb/tb_port_ext_arbiter.sv
// Self-checking bench for port_ext_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_port_ext_arbiter;

  localparam int NREQ  = 4;
  localparam int IN_W  = 2;
  localparam int OUT_W = 4;
  localparam int LEN_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*IN_W-1:0]  req_data;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       req_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic [1:0]            out_src;
`ifdef PORT_EXT_CNT_EN
  logic [15:0]           ext_fill_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_hold;
  int m_ptr, m_src, m_data, m_cnt;

  always #5 clk = ~clk;

  port_ext_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_len   (req_len),
    .req_signed(req_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef PORT_EXT_CNT_EN
    ,
    .ext_fill_cnt(ext_fill_cnt)
`endif
  );

  // Two's-complement interpretation of the low e bits, then truncated to OUT_W.
  function automatic int ext_ref(input int v, input int l, input bit s);
    int e, val;
    e = (l > IN_W) ? IN_W : l;
    if (e == 0) return 0;
    val = v % (1 << e);
    if (s && val >= (1 << (e - 1))) val = val - (1 << e);
    return val & ((1 << OUT_W) - 1);
  endfunction

  function automatic bit fill_ref(input int v, input int l, input bit s);
    int e;
    e = (l > IN_W) ? IN_W : l;
    if (e == 0 || e >= OUT_W) return 1'b0;
    return s && (((v >> (e - 1)) & 1) == 1);
  endfunction

  function automatic int model_win();
    if (!rst_n) return -1;
    if (m_hold && !out_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int w;
    w = model_win();
    return (w >= 0) ? NREQ'(1 << w) : '0;
  endfunction

  task automatic tick();
    int w, v, l;
    bit s;
    w = model_win();
    @(posedge clk);
    if (!rst_n) begin
      m_hold = 1'b0; m_ptr = 0; m_src = 0; m_data = 0; m_cnt = 0;
    end else if (w >= 0) begin
      v = int'(req_data[w*IN_W +: IN_W]);
      l = int'(req_len[w*LEN_W +: LEN_W]);
      s = req_signed[w];
      m_data = ext_ref(v, l, s);
      m_src  = w;
      m_ptr  = (w + 1) % NREQ;
      m_hold = 1'b1;
      if (fill_ref(v, l, s)) m_cnt = (m_cnt + 1) & 16'hFFFF;
    end else if (m_hold && out_ready) begin
      m_hold = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input int v, input int l, input bit s);
    req_data[r*IN_W +: IN_W]    = IN_W'(v);
    req_len[r*LEN_W +: LEN_W]   = LEN_W'(l);
    req_signed[r]               = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; out_ready = 1'b1;
    req_data = '1; req_len = '1; req_signed = '1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready_in_reset got=%b want=0000", req_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h s=%0d want v=0 d=0 s=0", out_valid, out_data, out_src);
    end
    rst_n = 1'b1; req_valid = '0;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready_idle got=%b want=0000", req_ready);
    end
  endtask

  task automatic test_extend();
    int cr[6]  = '{0, 0, 1, 1, 1, 1};
    int cv[6]  = '{1, 1, 2, 2, 2, 2};
    int cl[6]  = '{1, 1, 2, 2, 0, 3};
    bit cs[6]  = '{1, 0, 1, 0, 1, 1};
    logic [3:0] ce[6] = '{4'b1111, 4'b0001, 4'b1110, 4'b0010, 4'b0000, 4'b1110};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_req(cr[c], cv[c], cl[c], cs[c]);
      req_valid = NREQ'(1 << cr[c]);
      out_ready = 1'b1;
      tick();
      n_tests++;
      if (out_data !== ce[c] || out_valid !== 1'b1 || out_src !== 2'(cr[c])) begin
        n_fail++;
        $display("FAIL extend_case%0d got d=%b v=%b s=%0d want d=%b v=1 s=%0d",
                 c, out_data, out_valid, out_src, ce[c], cr[c]);
      end
      req_valid = '0;
      tick();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (req_ready !== NREQ'(1 << (k % NREQ))) begin
        n_fail++; $display("FAIL rr_ready_%0d got=%b want=%b", k, req_ready, NREQ'(1 << (k % NREQ)));
      end
      tick();
      n_tests++;
      if (out_src !== 2'(k % NREQ) || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL rr_src_%0d got s=%0d v=%b want s=%0d v=1", k, out_src, out_valid, k % NREQ);
      end
    end
  endtask

  // Runs straight after test_round_robin: holding src 0 with pointer at 1.
  task automatic test_stall();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL stall_ready_%0d got=%b want=0000", k, req_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== OUT_W'(m_data)) begin
        n_fail++;
        $display("FAIL stall_hold_%0d got v=%b s=%0d d=%h want v=1 s=0 d=%h", k, out_valid, out_src, out_data, OUT_W'(m_data));
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL stall_release_ready got=%b want=0010", req_ready);
    end
    tick();
    n_tests++;
    if (out_src !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_release_src got s=%0d v=%b want s=1 v=1", out_src, out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] want[3] = '{2'd2, 2'd2, 2'd3};
    logic [3:0] vld[3]  = '{4'b0100, 4'b0100, 4'b1001};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = vld[k];
      tick();
      n_tests++;
      if (out_src !== want[k] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL wrap_step%0d got s=%0d v=%b want s=%0d v=1", k, out_src, out_valid, want[k]);
      end
    end
  endtask

  task automatic test_reset_hold();
    do_reset();
    req_valid = 4'b0100; out_ready = 1'b0;
    tick();
    rst_n = 1'b0; req_valid = '1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_src !== 2'd0 || out_data !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_hold_out got v=%b s=%0d d=%h want v=0 s=0 d=0", out_valid, out_src, out_data);
    end
    rst_n = 1'b1; req_valid = 4'b1010; out_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL reset_hold_grant got=%b want=0010", req_ready);
    end
    tick();
    n_tests++;
    if (out_src !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_hold_src got s=%0d v=%b want s=1 v=1", out_src, out_valid);
    end
`ifdef PORT_EXT_CNT_EN
    for (int c = 0; c < 2; c++) begin
      do_reset();
      set_req(0, 1, 1, (c == 0));
      req_valid = 4'b0001;
      tick();
      n_tests++;
      if (ext_fill_cnt !== 16'((c == 0) ? 1 : 0)) begin
        n_fail++; $display("FAIL fill_cnt_s%0d got=%0d want=%0d", (c == 0), ext_fill_cnt, (c == 0) ? 1 : 0);
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp_ready;
    for (int c = 0; c < 400; c++) begin
      rst_n      = ($urandom_range(0, 39) != 0);
      req_valid  = NREQ'($urandom);
      req_data   = (NREQ*IN_W)'($urandom);
      req_len    = (NREQ*LEN_W)'($urandom);
      req_signed = NREQ'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = model_ready();
      n_tests++;
      if (req_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready_c%0d got=%b want=%b", c, req_ready, exp_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== m_hold || out_data !== OUT_W'(m_data) || out_src !== 2'(m_src)) begin
        n_fail++;
        $display("FAIL rand_out_c%0d got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                 c, out_valid, out_data, out_src, m_hold, OUT_W'(m_data), m_src);
      end
`ifdef PORT_EXT_CNT_EN
      n_tests++;
      if (ext_fill_cnt !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL rand_cnt_c%0d got=%0d want=%0d", c, ext_fill_cnt, m_cnt);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_len = '0; req_signed = '0; out_ready = 1'b0;
    m_hold = 1'b0; m_ptr = 0; m_src = 0; m_data = 0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_extend();
    test_round_robin();
    test_stall();
    test_wrap();
    test_reset_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
